instr_fetch_unit: RTL and testbench

Multi-cycle instruction fetch unit for the TSC 16-bit CPU: it issues read requests to instruction memory over a request/ready handshake, latches the returned word into the instruction register, and presents the decoded fields (opcode, func_code, register and immediate fields) to the control unit under a valid/ready handshake. It sits between instruction memory and the control unit and owns the fetch PC. Branch and jump redirects are accepted from the datapath, and halt is accepted from the control unit.

---
 rtl/instr_fetch_unit_pkg.sv | 28 ++
 rtl/instr_fetch_unit_field_split.sv | 27 ++
 rtl/instr_fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants, IR field layout and PC helper for the TSC instruction fetch unit.
// Optional FETCH_COUNT_EN (in instr_fetch_unit) adds the consumed-instruction counter.
package instr_fetch_unit_pkg;

   localparam int unsigned WORD_W   = 16;
   localparam int unsigned OPCODE_W = 4;
   localparam int unsigned REG_W    = 2;
   localparam int unsigned FUNC_W   = 6;
   localparam int unsigned IMM_W    = 8;
   localparam int unsigned TARGET_W = 12;
   localparam int unsigned COUNT_W  = 16;

   localparam logic [WORD_W-1:0] RESET_PC_DEF = 16'h0000;

   // R-format view of the instruction word; imm and target overlay the low bits
   typedef struct packed {
      logic [OPCODE_W-1:0] opcode;
      logic [REG_W-1:0]    rs;
      logic [REG_W-1:0]    rt;
      logic [REG_W-1:0]    rd;
      logic [FUNC_W-1:0]   func_code;
   } ir_fields_t;

   function automatic logic [WORD_W-1:0] pc_inc(input logic [WORD_W-1:0] pc_in);
      return WORD_W'(pc_in + WORD_W'(1));
   endfunction

endpackage

// File: rtl/instr_fetch_unit_field_split.sv
// Combinational split of the instruction register into decoder fields.
// Shared with decoder benches; no state.
module instr_field_split
   import instr_fetch_unit_pkg::*;
(
   input  logic [WORD_W-1:0]   i_ir,
   output logic [OPCODE_W-1:0] o_opcode,
   output logic [REG_W-1:0]    o_rs,
   output logic [REG_W-1:0]    o_rt,
   output logic [REG_W-1:0]    o_rd,
   output logic [FUNC_W-1:0]   o_func_code,
   output logic [IMM_W-1:0]    o_imm,
   output logic [TARGET_W-1:0] o_target
);

   ir_fields_t w_f;

   assign w_f         = ir_fields_t'(i_ir);
   assign o_opcode    = w_f.opcode;
   assign o_rs        = w_f.rs;
   assign o_rt        = w_f.rt;
   assign o_rd        = w_f.rd;
   assign o_func_code = w_f.func_code;
   assign o_imm       = i_ir[IMM_W-1:0];
   assign o_target    = i_ir[TARGET_W-1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch for the TSC 16-bit CPU: owns fetch PC, IR and redirect/halt.
// Define FETCH_COUNT_EN to add the o_num_inst consumed-instruction counter.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic                clk,
   input  logic                reset_n,
   output logic                o_mem_read_req,
   output logic [WORD_W-1:0]   o_mem_addr,
   input  logic [WORD_W-1:0]   i_mem_data,
   input  logic                i_mem_ready,
   output logic                o_ir_valid,
   input  logic                i_ir_ready,
   output logic [OPCODE_W-1:0] o_opcode,
   output logic [REG_W-1:0]    o_rs,
   output logic [REG_W-1:0]    o_rt,
   output logic [REG_W-1:0]    o_rd,
   output logic [FUNC_W-1:0]   o_func_code,
   output logic [IMM_W-1:0]    o_imm,
   output logic [TARGET_W-1:0] o_target,
   output logic [WORD_W-1:0]   o_pc,
   input  logic                i_redirect,
   input  logic [WORD_W-1:0]   i_redirect_pc,
   input  logic                i_halt,
   output logic                o_halted
`ifdef FETCH_COUNT_EN
   ,
   output logic [COUNT_W-1:0]  o_num_inst
`endif
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DROP   = 3'd2;
   localparam logic [2:0] ST_HOLD   = 3'd3;
   localparam logic [2:0] ST_HALTED = 3'd4;

   logic [2:0]        r_state;
   logic [WORD_W-1:0] r_fetch_pc;
   logic [WORD_W-1:0] r_pend_pc;
   logic              r_halt_pend;
   logic [WORD_W-1:0] r_ir;
   logic [WORD_W-1:0] r_pc;

   logic [2:0]        w_state_nxt;
   logic [WORD_W-1:0] w_fetch_pc_nxt;
   logic [WORD_W-1:0] w_pend_pc_nxt;
   logic              w_halt_pend_nxt;
   logic              w_ir_load;
   logic              w_req;

   // Next-state and datapath control; halt beats redirect, redirect beats handshake
   always_comb begin
      w_state_nxt     = r_state;
      w_fetch_pc_nxt  = r_fetch_pc;
      w_pend_pc_nxt   = r_pend_pc;
      w_halt_pend_nxt = r_halt_pend;
      w_ir_load       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_state_nxt = i_halt ? ST_HALTED : ST_FETCH;
         end
         ST_FETCH: begin
            if (i_halt) begin
               // A response arriving with halt has nothing left to drain
               w_state_nxt     = i_mem_ready ? ST_HALTED : ST_DROP;
               w_halt_pend_nxt = 1'b1;
            end else if (i_redirect) begin
               if (i_mem_ready) begin
                  w_fetch_pc_nxt = i_redirect_pc;
               end else begin
                  w_state_nxt   = ST_DROP;
                  w_pend_pc_nxt = i_redirect_pc;
               end
            end else if (i_mem_ready) begin
               w_ir_load      = 1'b1;
               w_fetch_pc_nxt = pc_inc(r_fetch_pc);
               w_state_nxt    = ST_HOLD;
            end
         end
         ST_DROP: begin
            if (i_redirect) w_pend_pc_nxt = i_redirect_pc;
            if (i_halt)     w_halt_pend_nxt = 1'b1;
            if (i_mem_ready) begin
               if (i_halt || r_halt_pend) begin
                  w_state_nxt = ST_HALTED;
               end else begin
                  w_state_nxt    = ST_FETCH;
                  w_fetch_pc_nxt = i_redirect ? i_redirect_pc : r_pend_pc;
               end
            end
         end
         ST_HOLD: begin
            if (i_halt) begin
               w_state_nxt = ST_HALTED;
            end else if (i_redirect) begin
               w_state_nxt    = ST_FETCH;
               w_fetch_pc_nxt = i_redirect_pc;
            end else if (i_ir_ready) begin
               w_state_nxt = ST_FETCH;
            end
         end
         ST_HALTED: begin
            w_state_nxt = ST_HALTED;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_fetch_pc  <= RESET_PC;
         r_pend_pc   <= RESET_PC;
         r_halt_pend <= 1'b0;
         r_ir        <= '0;
         r_pc        <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_fetch_pc  <= w_fetch_pc_nxt;
         r_pend_pc   <= w_pend_pc_nxt;
         r_halt_pend <= w_halt_pend_nxt;
         if (w_ir_load) begin
            r_ir <= i_mem_data;
            r_pc <= r_fetch_pc;
         end
      end
   end

`ifdef FETCH_COUNT_EN
   logic [COUNT_W-1:0] r_num_inst;

   // Counts accepted instructions; a redirect in the same cycle squashes the handshake
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_num_inst <= '0;
      end else if (r_state == ST_HOLD && i_ir_ready && !i_redirect) begin
         r_num_inst <= COUNT_W'(r_num_inst + COUNT_W'(1));
      end
   end

   assign o_num_inst = r_num_inst;
`endif

   assign w_req          = (r_state == ST_FETCH) || (r_state == ST_DROP);
   assign o_mem_read_req = w_req;
   assign o_mem_addr     = w_req ? r_fetch_pc : '0;
   assign o_ir_valid     = (r_state == ST_HOLD);
   assign o_halted       = (r_state == ST_HALTED);
   assign o_pc           = r_pc;

   instr_field_split u_split (
      .i_ir        (r_ir),
      .o_opcode    (o_opcode),
      .o_rs        (o_rs),
      .o_rt        (o_rt),
      .o_rd        (o_rd),
      .o_func_code (o_func_code),
      .o_imm       (o_imm),
      .o_target    (o_target)
   );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; memory responses are driven by hand each cycle.
// num_inst checks are present only when FETCH_COUNT_EN is defined.
module tb_instr_fetch_unit;

   logic        clk;
   logic        reset_n;
   logic        mem_read_req;
   logic [15:0] mem_addr;
   logic [15:0] mem_data;
   logic        mem_ready;
   logic        ir_valid;
   logic        ir_ready;
   logic [3:0]  opcode;
   logic [1:0]  rs, rt, rd;
   logic [5:0]  func_code;
   logic [7:0]  imm;
   logic [11:0] target;
   logic [15:0] pc;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        halt;
   logic        halted;
`ifdef FETCH_COUNT_EN
   logic [15:0] num_inst;
`endif

   int errors = 0;
   int checks = 0;

   instr_fetch_unit dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .o_mem_read_req (mem_read_req),
      .o_mem_addr     (mem_addr),
      .i_mem_data     (mem_data),
      .i_mem_ready    (mem_ready),
      .o_ir_valid     (ir_valid),
      .i_ir_ready     (ir_ready),
      .o_opcode       (opcode),
      .o_rs           (rs),
      .o_rt           (rt),
      .o_rd           (rd),
      .o_func_code    (func_code),
      .o_imm          (imm),
      .o_target       (target),
      .o_pc           (pc),
      .i_redirect     (redirect),
      .i_redirect_pc  (redirect_pc),
      .i_halt         (halt),
      .o_halted       (halted)
`ifdef FETCH_COUNT_EN
      ,
      .o_num_inst     (num_inst)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b0; mem_data = '0; mem_ready = 1'b0; ir_ready = 1'b0;
      redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
      repeat (2) step();
      chk("rst_req", 32'(mem_read_req), 32'h0);
      chk("rst_valid", 32'(ir_valid), 32'h0);
      chk("rst_halted", 32'(halted), 32'h0);
      chk("rst_addr", 32'(mem_addr), 32'h0);
      chk("rst_pc", 32'(pc), 32'h0);
      chk("rst_opcode", 32'(opcode), 32'h0);
`ifdef FETCH_COUNT_EN
      chk("rst_num", 32'(num_inst), 32'h0);
`endif

      // first fetch at RESET_PC, memory answers after 2 cycles
      reset_n = 1'b1; step();
      chk("f0_req", 32'(mem_read_req), 32'h1);
      chk("f0_addr", 32'(mem_addr), 32'h0000);
      step();
      chk("f0_wait_req", 32'(mem_read_req), 32'h1);
      chk("f0_wait_valid", 32'(ir_valid), 32'h0);
      mem_ready = 1'b1; mem_data = 16'h6A05; step(); mem_ready = 1'b0;
      chk("i0_valid", 32'(ir_valid), 32'h1);
      chk("i0_opcode", 32'(opcode), 32'h6);
      chk("i0_rs", 32'(rs), 32'h2);
      chk("i0_rt", 32'(rt), 32'h2);
      chk("i0_rd", 32'(rd), 32'h0);
      chk("i0_func", 32'(func_code), 32'h05);
      chk("i0_imm", 32'(imm), 32'h05);
      chk("i0_target", 32'(target), 32'hA05);
      chk("i0_pc", 32'(pc), 32'h0000);
      chk("i0_req", 32'(mem_read_req), 32'h0);
      step();
      chk("i0_hold_valid", 32'(ir_valid), 32'h1);
      chk("i0_hold_opcode", 32'(opcode), 32'h6);

      // back-to-back handshakes at 0000 and 0001
      ir_ready = 1'b1; step(); ir_ready = 1'b0;
      chk("f1_valid", 32'(ir_valid), 32'h0);
      chk("f1_req", 32'(mem_read_req), 32'h1);
      chk("f1_addr", 32'(mem_addr), 32'h0001);
      mem_ready = 1'b1; mem_data = 16'h1234; step(); mem_ready = 1'b0;
      chk("i1_valid", 32'(ir_valid), 32'h1);
      chk("i1_pc", 32'(pc), 32'h0001);
      chk("i1_opcode", 32'(opcode), 32'h1);
      ir_ready = 1'b1; step(); ir_ready = 1'b0;
      chk("f2_req", 32'(mem_read_req), 32'h1);
      chk("f2_addr", 32'(mem_addr), 32'h0002);
`ifdef FETCH_COUNT_EN
      chk("num_after_2", 32'(num_inst), 32'h2);
`endif

      // redirect to 0040 while fetching, response arrives 3 cycles later
      redirect = 1'b1; redirect_pc = 16'h0040; step(); redirect = 1'b0;
      chk("drop_req", 32'(mem_read_req), 32'h1);
      chk("drop_addr", 32'(mem_addr), 32'h0002);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("drop_addr_hold", 32'(mem_addr), 32'h0002);
         chk("drop_no_valid", 32'(ir_valid), 32'h0);
      end
      mem_ready = 1'b1; mem_data = 16'hFFFF; step(); mem_ready = 1'b0;
      chk("rd_no_valid", 32'(ir_valid), 32'h0);
      chk("rd_req", 32'(mem_read_req), 32'h1);
      chk("rd_addr", 32'(mem_addr), 32'h0040);

      // redirect to 0100 coincident with handshake: redirect wins
      mem_ready = 1'b1; mem_data = 16'h2345; step(); mem_ready = 1'b0;
      chk("i40_valid", 32'(ir_valid), 32'h1);
      chk("i40_pc", 32'(pc), 32'h0040);
      chk("i40_opcode", 32'(opcode), 32'h2);
      ir_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0100; step();
      ir_ready = 1'b0; redirect = 1'b0;
      chk("rh_valid", 32'(ir_valid), 32'h0);
      chk("rh_addr", 32'(mem_addr), 32'h0100);
`ifdef FETCH_COUNT_EN
      chk("rh_num", 32'(num_inst), 32'h2);
`endif

      // redirect together with mem_ready in FETCH: data dropped, stay in FETCH at FFFF
      mem_ready = 1'b1; mem_data = 16'h5555; redirect = 1'b1; redirect_pc = 16'hFFFF; step();
      mem_ready = 1'b0; redirect = 1'b0;
      chk("rr_valid", 32'(ir_valid), 32'h0);
      chk("rr_req", 32'(mem_read_req), 32'h1);
      chk("rr_addr", 32'(mem_addr), 32'hFFFF);
      mem_ready = 1'b1; mem_data = 16'h3000; step(); mem_ready = 1'b0;
      chk("iff_valid", 32'(ir_valid), 32'h1);
      chk("iff_pc", 32'(pc), 32'hFFFF);
      chk("iff_opcode", 32'(opcode), 32'h3);
      ir_ready = 1'b1; step(); ir_ready = 1'b0;
      chk("wrap_req", 32'(mem_read_req), 32'h1);
      chk("wrap_addr", 32'(mem_addr), 32'h0000);
`ifdef FETCH_COUNT_EN
      chk("wrap_num", 32'(num_inst), 32'h3);
`endif

      // halt during FETCH drains the outstanding response
      halt = 1'b1; step(); halt = 1'b0;
      chk("hd_req", 32'(mem_read_req), 32'h1);
      chk("hd_addr", 32'(mem_addr), 32'h0000);
      chk("hd_halted", 32'(halted), 32'h0);
      step();
      chk("hd_req2", 32'(mem_read_req), 32'h1);
      mem_ready = 1'b1; mem_data = 16'h7777; step(); mem_ready = 1'b0;
      chk("h_halted", 32'(halted), 32'h1);
      chk("h_req", 32'(mem_read_req), 32'h0);
      chk("h_valid", 32'(ir_valid), 32'h0);
      redirect = 1'b1; redirect_pc = 16'h0200; step(); redirect = 1'b0;
      repeat (2) step();
      chk("h_sticky", 32'(halted), 32'h1);
      chk("h_sticky_req", 32'(mem_read_req), 32'h0);

      // asynchronous reset leaves HALTED, fetch restarts at RESET_PC
      reset_n = 1'b0; #1;
      chk("ar_halted", 32'(halted), 32'h0);
      chk("ar_req", 32'(mem_read_req), 32'h0);
      chk("ar_pc", 32'(pc), 32'h0);
`ifdef FETCH_COUNT_EN
      chk("ar_num", 32'(num_inst), 32'h0);
`endif
      step(); reset_n = 1'b1; step();
      chk("rs_req", 32'(mem_read_req), 32'h1);
      chk("rs_addr", 32'(mem_addr), 32'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
